// File: rtl/memory_controller_pkg.sv
// rtl/memory_controller_pkg.sv - shared encodings and helpers for the memory controller
package memory_controller_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] IO_ADDR_BASE_DEF = 32'h0003_0000;
  localparam int unsigned IO_WINDOW        = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_e;
  typedef enum logic [1:0] {CL_STORE, CL_LOAD, CL_FETCH} client_e;

  function automatic logic [2:0] byte_count(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_controller_load_extend.sv
// rtl/memory_controller_load_extend.sv - sign/zero extension of an assembled load word
module mem_load_extend
  import memory_controller_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (funct3)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   data = {24'h0, raw[7:0]};
      F3_HU:   data = {16'h0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - byte-serial RAM/IO bus owner for store, load and fetch clients
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = IO_ADDR_BASE_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  roll_back,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  lsb_store,
  input  logic [ADDR_WIDTH-1:0] store_address,
  input  logic [31:0]           data_store,
  input  logic [2:0]            op_type_store,
  output logic                  finish_store,
  input  logic                  lsb_load,
  input  logic [ADDR_WIDTH-1:0] load_address,
  input  logic [2:0]            op_type_load,
  output logic                  finish_load,
  output logic [31:0]           data_load,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data
);

  state_e                  state_q, state_d;
  client_e                 client_q, client_d;
  logic [2:0]              k_q, k_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [2:0]              f3_q, f3_d;
  logic [31:0]             word_q, word_d;
  logic [ADDR_WIDTH-1:0]   mem_a_q, mem_a_d;
  logic [7:0]              mem_dout_q, mem_dout_d;
  logic                    mem_wr_q, mem_wr_d;
  logic                    fin_st_q, fin_st_d;
  logic                    fin_ld_q, fin_ld_d;
  logic                    if_done_q, if_done_d;
  logic [31:0]             data_load_q, data_load_d;
  logic [31:0]             if_data_q, if_data_d;

  logic [2:0]              n_bytes;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [1:0]              cap_idx;
  logic [31:0]             word_cap;
  logic [31:0]             ext_data;

  function automatic logic io_hold(input logic full, input logic [ADDR_WIDTH-1:0] a);
    return full && ((a - IO_ADDR_BASE) < ADDR_WIDTH'(IO_WINDOW));
  endfunction

  assign n_bytes  = byte_count(f3_q);
  assign cur_addr = base_q + ADDR_WIDTH'(k_q);
  // In READ, k runs one ahead of the byte landing on mem_din.
  assign cap_idx  = 2'(k_q - 3'd1);

  always_comb begin
    word_cap = word_q;
    word_cap[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  mem_load_extend u_ext (
    .funct3 (f3_q),
    .raw    (word_cap),
    .data   (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    client_d    = client_q;
    k_d         = k_q;
    base_d      = base_q;
    f3_d        = f3_q;
    word_d      = word_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    fin_st_d    = fin_st_q;
    fin_ld_d    = fin_ld_q;
    if_done_d   = if_done_q;
    data_load_d = data_load_q;
    if_data_d   = if_data_q;

    if (rdy_in) begin
      mem_wr_d  = FALSE;
      fin_st_d  = FALSE;
      fin_ld_d  = FALSE;
      if_done_d = FALSE;

      case (state_q)
        ST_IDLE: begin
          if (!roll_back) begin
            if (lsb_store) begin
              state_d  = ST_WRITE;
              client_d = CL_STORE;
              base_d   = store_address;
              f3_d     = op_type_store;
              word_d   = data_store;
              mem_a_d  = store_address;
              if (io_hold(io_buffer_full, store_address)) begin
                k_d = 3'd0;
              end else begin
                mem_wr_d   = TRUE;
                mem_dout_d = data_store[7:0];
                k_d        = 3'd1;
              end
            end else if (lsb_load) begin
              state_d  = ST_READ;
              client_d = CL_LOAD;
              base_d   = load_address;
              f3_d     = op_type_load;
              word_d   = '0;
              k_d      = 3'd0;
            end else if (if_req) begin
              state_d  = ST_READ;
              client_d = CL_FETCH;
              base_d   = if_addr;
              f3_d     = F3_W;
              word_d   = '0;
              k_d      = 3'd0;
            end
          end
        end

        ST_WRITE: begin
          if (k_q == n_bytes) begin
            fin_st_d = TRUE;
            state_d  = ST_DONE;
          end else begin
            mem_a_d = cur_addr;
            if (!io_hold(io_buffer_full, cur_addr)) begin
              mem_wr_d   = TRUE;
              mem_dout_d = word_q[{k_q[1:0], 3'b000} +: 8];
              k_d        = k_q + 3'd1;
            end
          end
        end

        ST_READ: begin
          if (roll_back) begin
            state_d = ST_IDLE;
          end else begin
            if (k_q < n_bytes) mem_a_d = cur_addr;
            if (k_q != 3'd0) word_d = word_cap;
            if (k_q == n_bytes) begin
              state_d = ST_DONE;
              if (client_q == CL_LOAD) begin
                fin_ld_d    = TRUE;
                data_load_d = ext_data;
              end else begin
                if_done_d = TRUE;
                if_data_d = word_cap;
              end
            end else begin
              k_d = k_q + 3'd1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      client_q    <= CL_LOAD;
      k_q         <= '0;
      base_q      <= '0;
      f3_q        <= '0;
      word_q      <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      fin_st_q    <= 1'b0;
      fin_ld_q    <= 1'b0;
      if_done_q   <= 1'b0;
      data_load_q <= '0;
      if_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      client_q    <= client_d;
      k_q         <= k_d;
      base_q      <= base_d;
      f3_q        <= f3_d;
      word_q      <= word_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      fin_st_q    <= fin_st_d;
      fin_ld_q    <= fin_ld_d;
      if_done_q   <= if_done_d;
      data_load_q <= data_load_d;
      if_data_q   <= if_data_d;
    end
  end

  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign mem_wr       = mem_wr_q;
  assign finish_store = fin_st_q;
  assign finish_load  = fin_ld_q;
  assign if_done      = if_done_q;
  assign data_load    = data_load_q;
  assign if_data      = if_data_q;

endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - self-checking bench for memory_controller
module tb_memory_controller;

  logic        clk_in, rst_in, rdy_in, roll_back, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        lsb_store;
  logic [31:0] store_address, data_store;
  logic [2:0]  op_type_store;
  logic        finish_store;
  logic        lsb_load;
  logic [31:0] load_address;
  logic [2:0]  op_type_load;
  logic        finish_load;
  logic [31:0] data_load;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  memory_controller dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .lsb_store(lsb_store), .store_address(store_address),
    .data_store(data_store), .op_type_store(op_type_store), .finish_store(finish_store),
    .lsb_load(lsb_load), .load_address(load_address), .op_type_load(op_type_load),
    .finish_load(finish_load), .data_load(data_load), .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_data(if_data)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // 4 KiB byte RAM with combinational read; higher addresses alias onto it.
  logic [7:0] ram [0:4095];
  logic       ram_clr;
  always @(posedge clk_in) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    end else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
    end
  end
  assign mem_din = ram[mem_a[11:0]];

  logic [7:0] exp_mem [0:4095];

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    for (int i = 0; i < nbytes(f3); i++) exp_mem[12'(a + 32'(i))] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    longint v;
    int     n;
    n = nbytes(f3);
    v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(exp_mem[12'(a + 32'(i))]);
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                          output int lat);
    int c0;
    @(negedge clk_in);
    lsb_store = 1'b1; store_address = a; data_store = d; op_type_store = f3;
    c0 = cyc; lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (finish_store === 1'b1) begin lat = cyc - c0 - 1; break; end
    end
    lsb_store = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3,
                         output logic [31:0] d, output int lat);
    int c0;
    @(negedge clk_in);
    lsb_load = 1'b1; load_address = a; op_type_load = f3;
    c0 = cyc; lat = -1; d = 32'hx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (finish_load === 1'b1) begin lat = cyc - c0 - 1; d = data_load; break; end
    end
    lsb_load = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
    int c0;
    @(negedge clk_in);
    if_req = 1'b1; if_addr = a;
    c0 = cyc; lat = -1; d = 32'hx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (if_done === 1'b1) begin lat = cyc - c0 - 1; d = if_data; break; end
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    n_tests++;
    if ({mem_a, mem_dout, mem_wr} !== 41'h0) begin
      n_fail++; $display("FAIL reset_bus: got a=%h dout=%h wr=%b want all 0", mem_a, mem_dout, mem_wr);
    end
    n_tests++;
    if ({finish_store, finish_load, if_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b%b%b want 000", finish_store, finish_load, if_done);
    end
    n_tests++;
    if ({data_load, if_data} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h want 0", data_load, if_data);
    end
    rst_in = 1'b0; ram_clr = 1'b0;
    for (int i = 0; i < 4096; i++) exp_mem[i] = 8'h00;
    @(negedge clk_in);
  endtask

  task automatic test_store_word();
    logic [31:0] w;
    w = 32'h1122_3344;
    @(negedge clk_in);
    lsb_store = 1'b1; store_address = 32'h100; data_store = w; op_type_store = 3'b010;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk_in);
      n_tests++;
      if ({mem_wr, mem_a, mem_dout, finish_store} !== {1'b1, 32'h100 + 32'(e), w[8*e +: 8], 1'b0}) begin
        n_fail++;
        $display("FAIL sw_byte%0d: got wr=%b a=%h d=%h fin=%b want wr=1 a=%h d=%h fin=0",
                 e, mem_wr, mem_a, mem_dout, finish_store, 32'h100 + 32'(e), w[8*e +: 8]);
      end
    end
    @(negedge clk_in);
    n_tests++;
    if ({finish_store, mem_wr} !== 2'b10) begin
      n_fail++; $display("FAIL sw_finish: got fin=%b wr=%b want fin=1 wr=0", finish_store, mem_wr);
    end
    lsb_store = 1'b0;
    model_store(32'h100, w, 3'b010);
    @(negedge clk_in);
    n_tests++;
    if (finish_store !== 1'b0) begin
      n_fail++; $display("FAIL sw_pulse_width: got fin=%b want 0", finish_store);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] d;
    int lat;
    do_store(32'h200, 32'h0000_0080, 3'b000, lat);
    model_store(32'h200, 32'h80, 3'b000);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL sb_latency: got %0d want 1", lat); end
    do_load(32'h200, 3'b000, d, lat);
    n_tests++;
    if (d !== 32'hFFFF_FF80 || lat !== 2) begin
      n_fail++; $display("FAIL lb_sext: got %h lat %0d want ffffff80 lat 2", d, lat);
    end
    do_load(32'h200, 3'b100, d, lat);
    n_tests++;
    if (d !== 32'h0000_0080 || lat !== 2) begin
      n_fail++; $display("FAIL lbu_zext: got %h lat %0d want 00000080 lat 2", d, lat);
    end
    do_load(32'h100, 3'b010, d, lat);
    n_tests++;
    if (d !== 32'h1122_3344 || lat !== 5) begin
      n_fail++; $display("FAIL lw_readback: got %h lat %0d want 11223344 lat 5", d, lat);
    end
  endtask

  task automatic test_priority();
    int t_s, t_l, t_f, c0;
    logic [31:0] d_l, d_f, w;
    w = $urandom;
    t_s = -1; t_l = -1; t_f = -1; d_l = 'x; d_f = 'x;
    @(negedge clk_in);
    lsb_store = 1'b1; store_address = 32'h300; data_store = w; op_type_store = 3'b010;
    lsb_load  = 1'b1; load_address  = 32'h302; op_type_load = 3'b001;
    if_req    = 1'b1; if_addr       = 32'h300;
    c0 = cyc;
    for (int i = 0; i < 60 && t_f < 0; i++) begin
      @(negedge clk_in);
      if (finish_store === 1'b1) begin t_s = cyc - c0 - 1; lsb_store = 1'b0; end
      if (finish_load === 1'b1) begin t_l = cyc - c0 - 1; d_l = data_load; lsb_load = 1'b0; end
      if (if_done === 1'b1) begin t_f = cyc - c0 - 1; d_f = if_data; if_req = 1'b0; end
    end
    lsb_store = 1'b0; lsb_load = 1'b0; if_req = 1'b0;
    model_store(32'h300, w, 3'b010);
    n_tests++;
    if (t_s !== 4 || t_l !== 9 || t_f !== 16) begin
      n_fail++; $display("FAIL priority_order: got edges s=%0d l=%0d f=%0d want 4 9 16", t_s, t_l, t_f);
    end
    n_tests++;
    if (d_l !== model_load(32'h302, 3'b001) || d_f !== w) begin
      n_fail++; $display("FAIL priority_data: got ld=%h if=%h want ld=%h if=%h",
                         d_l, d_f, model_load(32'h302, 3'b001), w);
    end
  endtask

  task automatic test_rollback();
    int cnt, lat, c0;
    logic [31:0] d, w;
    @(negedge clk_in);
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk_in);
    @(negedge clk_in);
    roll_back = 1'b1; if_req = 1'b0;
    @(negedge clk_in);
    roll_back = 1'b0; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      cnt += int'(if_done) + int'(mem_wr);
    end
    n_tests++;
    if (cnt !== 0) begin n_fail++; $display("FAIL rb_fetch_abort: got %0d pulses/writes want 0", cnt); end
    do_fetch(32'h100, d, lat);
    n_tests++;
    if (d !== 32'h1122_3344 || lat !== 5) begin
      n_fail++; $display("FAIL rb_fresh_fetch: got %h lat %0d want 11223344 lat 5", d, lat);
    end

    @(negedge clk_in);
    lsb_load = 1'b1; load_address = 32'h100; op_type_load = 3'b010;
    repeat (5) @(negedge clk_in);
    roll_back = 1'b1; lsb_load = 1'b0; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      cnt += int'(finish_load);
      roll_back = 1'b0;
    end
    n_tests++;
    if (cnt !== 0) begin n_fail++; $display("FAIL rb_final_capture: got %0d pulses want 0", cnt); end

    w = $urandom;
    @(negedge clk_in);
    lsb_store = 1'b1; store_address = 32'h310; data_store = w; op_type_store = 3'b010;
    c0 = cyc; lat = -1;
    @(negedge clk_in);
    roll_back = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (finish_store === 1'b1) begin lat = cyc - c0 - 1; break; end
    end
    lsb_store = 1'b0; roll_back = 1'b0;
    model_store(32'h310, w, 3'b010);
    do_load(32'h310, 3'b010, d, cnt);
    n_tests++;
    if (lat !== 4 || d !== w) begin
      n_fail++; $display("FAIL rb_store_ignored: got lat %0d data %h want lat 4 data %h", lat, d, w);
    end
  endtask

  task automatic test_io_stall();
    int cnt, lat;
    io_buffer_full = 1'b1;
    @(negedge clk_in);
    lsb_store = 1'b1; store_address = 32'h3_0000; data_store = 32'h0000_00A5; op_type_store = 3'b000;
    cnt = 0;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk_in);
      cnt += int'(mem_wr) + int'(finish_store);
    end
    n_tests++;
    if (cnt !== 0) begin n_fail++; $display("FAIL io_hold: got %0d writes want 0", cnt); end
    io_buffer_full = 1'b0;
    @(negedge clk_in);
    n_tests++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h3_0000, 8'hA5}) begin
      n_fail++; $display("FAIL io_release: got wr=%b a=%h d=%h want wr=1 a=00030000 d=a5", mem_wr, mem_a, mem_dout);
    end
    @(negedge clk_in);
    n_tests++;
    if ({finish_store, mem_wr} !== 2'b10) begin
      n_fail++; $display("FAIL io_finish: got fin=%b wr=%b want fin=1 wr=0", finish_store, mem_wr);
    end
    lsb_store = 1'b0;
    model_store(32'h3_0000, 32'hA5, 3'b000);
    io_buffer_full = 1'b1;
    do_store(32'h3_0008, 32'h5A, 3'b000, lat);
    model_store(32'h3_0008, 32'h5A, 3'b000);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL io_above_window: got lat %0d want 1", lat); end
    do_store(32'h2_FFFF, 32'h3C, 3'b000, lat);
    model_store(32'h2_FFFF, 32'h3C, 3'b000);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL io_below_window: got lat %0d want 1", lat); end
    io_buffer_full = 1'b0;
  endtask

  task automatic test_rdy_stall();
    logic [31:0] w, d;
    logic [73:0] snap;
    int c0, lat;
    w = $urandom;
    do_store(32'h320, w, 3'b010, lat);
    model_store(32'h320, w, 3'b010);
    @(negedge clk_in);
    lsb_load = 1'b1; load_address = 32'h320; op_type_load = 3'b010;
    c0 = cyc;
    repeat (3) @(negedge clk_in);
    snap = {mem_a, mem_dout, mem_wr, finish_load, data_load};
    rdy_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      n_tests++;
      if ({mem_a, mem_dout, mem_wr, finish_load, data_load} !== snap) begin
        n_fail++; $display("FAIL rdy_freeze%0d: got a=%h wr=%b fin=%b want a=%h wr=%b fin=%b",
                           i, mem_a, mem_wr, finish_load, snap[73:42], snap[33], snap[32]);
      end
    end
    rdy_in = 1'b1; lat = -1; d = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (finish_load === 1'b1) begin lat = cyc - c0 - 1; d = data_load; break; end
    end
    lsb_load = 1'b0;
    n_tests++;
    if (lat !== 7 || d !== w) begin
      n_fail++; $display("FAIL rdy_resume: got lat %0d data %h want lat 7 data %h", lat, d, w);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int lat;
    @(negedge clk_in);
    lsb_load = 1'b1; load_address = 32'h320; op_type_load = 3'b010;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1; lsb_load = 1'b0;
    #1;
    n_tests++;
    if ({mem_a, mem_dout, mem_wr, finish_load, data_load} !== 74'h0) begin
      n_fail++; $display("FAIL reset_mid: got a=%h wr=%b fin=%b data=%h want all 0", mem_a, mem_wr, finish_load, data_load);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    do_load(32'h320, 3'b010, d, lat);
    n_tests++;
    if (d !== model_load(32'h320, 3'b010) || lat !== 5) begin
      n_fail++; $display("FAIL reset_recover: got %h lat %0d want %h lat 5", d, lat, model_load(32'h320, 3'b010));
    end
  endtask

  task automatic test_random();
    logic [2:0]  st_ops [3] = '{3'b000, 3'b001, 3'b010};
    logic [2:0]  ld_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] a, d, w;
    logic [2:0]  f3;
    int lat;
    for (int op = 0; op < 60; op++) begin
      a = 32'h400 + 32'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0: begin
          f3 = st_ops[$urandom_range(0, 2)];
          w = $urandom;
          do_store(a, w, f3, lat);
          model_store(a, w, f3);
          n_tests++;
          if (lat !== nbytes(f3)) begin
            n_fail++; $display("FAIL rand_store op%0d: got lat %0d want %0d", op, lat, nbytes(f3));
          end
        end
        1: begin
          f3 = ld_ops[$urandom_range(0, 4)];
          do_load(a, f3, d, lat);
          n_tests++;
          if (d !== model_load(a, f3) || lat !== nbytes(f3) + 1) begin
            n_fail++; $display("FAIL rand_load op%0d f3=%0d a=%h: got %h lat %0d want %h lat %0d",
                               op, f3, a, d, lat, model_load(a, f3), nbytes(f3) + 1);
          end
        end
        default: begin
          do_fetch(a, d, lat);
          n_tests++;
          if (d !== model_load(a, 3'b010) || lat !== 5) begin
            n_fail++; $display("FAIL rand_fetch op%0d a=%h: got %h lat %0d want %h lat 5",
                               op, a, d, lat, model_load(a, 3'b010));
          end
        end
      endcase
    end
  endtask

  initial begin
    rst_in = 1'b1; ram_clr = 1'b1; rdy_in = 1'b1; roll_back = 1'b0; io_buffer_full = 1'b0;
    lsb_store = 1'b0; store_address = '0; data_store = '0; op_type_store = '0;
    lsb_load = 1'b0; load_address = '0; op_type_load = '0;
    if_req = 1'b0; if_addr = '0;
    test_reset();
    test_store_word();
    test_load_ext();
    test_priority();
    test_rollback();
    test_io_stall();
    test_rdy_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
